nes_joypad: RTL and testbench

NES_JOYPAD -- requirements
Module: nes_joypad

---
 rtl/joypad_pkg.sv | 24 ++
 rtl/joypad_debounce.sv | 72 +++++++
 rtl/nes_joypad.sv | 78 +++++++
 tb/tb_nes_joypad.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/joypad_pkg.sv
// Shared constants and types for the NES joypad block: button bit positions and pad counts.
// Button vectors are active-high, bit 0 = A through bit 7 = Right.
package joypad_pkg;

    localparam int NUM_BUTTONS = 8;
    localparam int NUM_PADS    = 2;

    localparam int BTN_A      = 0;
    localparam int BTN_B      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;

    typedef logic [NUM_BUTTONS-1:0] btn_t;

    // One serial read step: drop the bit just presented, feed the fill value in at the top.
    function automatic btn_t shift_in(input btn_t cur, input logic fill);
        return {fill, cur[NUM_BUTTONS-1:1]};
    endfunction

endpackage

// File: rtl/joypad_debounce.sv
// Two-flop synchronizer plus per-button debounce filter for one pad's eight buttons.
// Latency: 2 cycles when DEBOUNCE_CYCLES = 0, otherwise 2 + DEBOUNCE_CYCLES cycles of stable input.
module joypad_debounce
    import joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000
) (
    input  logic clk,
    input  logic rst,
    input  btn_t raw_i,
    output btn_t state_o
);

    btn_t sync1_q;
    btn_t sync2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= raw_i;
            sync2_q <= sync1_q;
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            assign state_o = sync2_q;
        end else begin : g_filter
            localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
            localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

            btn_t          state_q;
            btn_t          state_d;
            logic [CW-1:0] cnt_q [NUM_BUTTONS];
            logic [CW-1:0] cnt_d [NUM_BUTTONS];

            // Counter tracks consecutive cycles of disagreement; any agreement clears it.
            always_comb begin
                state_d = state_q;
                for (int i = 0; i < NUM_BUTTONS; i++) begin
                    cnt_d[i] = '0;
                    if (sync2_q[i] != state_q[i]) begin
                        if (cnt_q[i] == LAST) begin
                            state_d[i] = sync2_q[i];
                        end else begin
                            cnt_d[i] = cnt_q[i] + CW'(1);
                        end
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    state_q <= '0;
                    for (int i = 0; i < NUM_BUTTONS; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else begin
                    state_q <= state_d;
                    for (int i = 0; i < NUM_BUTTONS; i++) begin
                        cnt_q[i] <= cnt_d[i];
                    end
                end
            end

            assign state_o = state_q;
        end
    endgenerate

endmodule

// File: rtl/nes_joypad.sv
// NES $4016/$4017 joypad interface: debounced buttons latched on strobe, shifted out one bit per read edge.
// Latency: new serial bit visible the cycle after a read edge; no backpressure, CPU pulses are never stalled.
module nes_joypad
    import joypad_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 20000,
    parameter bit FILL_ONES       = 1'b1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [2:0]          ctrl_strobe,
    input  logic [NUM_PADS-1:0] ctrl_out,
    input  logic [7:0]          buttons0,
    input  logic [7:0]          buttons1,
    output logic [NUM_PADS-1:0] ctrl_data
);

    btn_t                raw      [NUM_PADS];
    btn_t                deb      [NUM_PADS];
    btn_t                sr_q     [NUM_PADS];
    btn_t                sr_d     [NUM_PADS];
    logic [NUM_PADS-1:0] rd_q;
    logic [NUM_PADS-1:0] rd_edge;
    logic                strobe;
    logic                unused_strobe_bits;

    assign raw[0] = buttons0;
    assign raw[1] = buttons1;

    // Only bit 0 of the $4016 latch drives the pads; expansion bits are not wired here.
    assign strobe             = ctrl_strobe[0];
    assign unused_strobe_bits = ^ctrl_strobe[2:1];

    genvar p;
    generate
        for (p = 0; p < NUM_PADS; p++) begin : g_pad
            joypad_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk    (clk),
                .rst    (rst),
                .raw_i  (raw[p]),
                .state_o(deb[p])
            );

            assign ctrl_data[p] = sr_q[p][BTN_A];
        end
    endgenerate

    // A read held high across CPU stall cycles still counts as one edge.
    assign rd_edge = ctrl_out & ~rd_q;

    always_comb begin
        for (int i = 0; i < NUM_PADS; i++) begin
            sr_d[i] = sr_q[i];
            if (strobe) begin
                sr_d[i] = deb[i];
            end else if (rd_edge[i]) begin
                sr_d[i] = shift_in(sr_q[i], FILL_ONES);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q <= '0;
            for (int i = 0; i < NUM_PADS; i++) begin
                sr_q[i] <= '0;
            end
        end else begin
            rd_q <= ctrl_out;
            for (int i = 0; i < NUM_PADS; i++) begin
                sr_q[i] <= sr_d[i];
            end
        end
    end

endmodule

// File: tb/tb_nes_joypad.sv
// Directed bench for nes_joypad: one bypass-debounce instance and one with a 10-cycle debounce.
module tb_nes_joypad;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] ctrl_strobe;
    logic [1:0] ctrl_out;
    logic [7:0] buttons0;
    logic [7:0] buttons1;
    logic [1:0] data0;
    logic [1:0] data_db;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nes_joypad #(
        .DEBOUNCE_CYCLES(0),
        .FILL_ONES      (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ctrl_strobe(ctrl_strobe),
        .ctrl_out   (ctrl_out),
        .buttons0   (buttons0),
        .buttons1   (buttons1),
        .ctrl_data  (data0)
    );

    nes_joypad #(
        .DEBOUNCE_CYCLES(10),
        .FILL_ONES      (1'b1)
    ) dut_db (
        .clk        (clk),
        .rst        (rst),
        .ctrl_strobe(ctrl_strobe),
        .ctrl_out   (ctrl_out),
        .buttons0   (buttons0),
        .buttons1   (buttons1),
        .ctrl_data  (data_db)
    );

    // All stimulus changes and samples happen on the falling edge.
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic latch();
        ctrl_strobe[0] = 1'b1;
        cycles(2);
        ctrl_strobe[0] = 1'b0;
    endtask

    task automatic read_pulse(input int p);
        ctrl_out[p] = 1'b1;
        cycles(1);
        ctrl_out[p] = 1'b0;
        cycles(1);
    endtask

    task automatic test_reset();
        buttons0 = 8'hFF;
        buttons1 = 8'hFF;
        rst = 1'b1;
        cycles(3);
        n_total++;
        if (data0 !== 2'b00) $display("FAIL reset_data0: got %b want 00", data0);
        else n_pass++;
        n_total++;
        if (data_db !== 2'b00) $display("FAIL reset_data_db: got %b want 00", data_db);
        else n_pass++;
        rst = 1'b0;
    endtask

    task automatic test_latch_read();
        logic [9:0] exp;
        exp = 10'b11_1000_0101;
        buttons0 = 8'b1000_0101;
        buttons1 = 8'h00;
        cycles(4);
        latch();
        buttons0 = 8'h00;
        for (int i = 0; i < 10; i++) begin
            n_total++;
            if (data0[0] !== exp[i]) $display("FAIL latch_read[%0d]: got %b want %b", i, data0[0], exp[i]);
            else n_pass++;
            read_pulse(0);
        end
    endtask

    task automatic test_strobe_held();
        buttons0 = 8'h01;
        cycles(4);
        ctrl_strobe[0] = 1'b1;
        cycles(2);
        for (int i = 0; i < 3; i++) begin
            read_pulse(0);
            n_total++;
            if (data0[0] !== 1'b1) $display("FAIL strobe_held[%0d]: got %b want 1", i, data0[0]);
            else n_pass++;
        end
        ctrl_strobe[0] = 1'b0;
        cycles(1);
        n_total++;
        if (data0[0] !== 1'b1) $display("FAIL strobe_held_first_read: got %b want 1", data0[0]);
        else n_pass++;
        read_pulse(0);
        n_total++;
        if (data0[0] !== 1'b0) $display("FAIL strobe_held_second_read: got %b want 0", data0[0]);
        else n_pass++;
    endtask

    task automatic test_stretched();
        buttons1 = 8'h03;
        cycles(4);
        latch();
        n_total++;
        if (data0[1] !== 1'b1) $display("FAIL stretched_a: got %b want 1", data0[1]);
        else n_pass++;
        ctrl_out[1] = 1'b1;
        cycles(4);
        n_total++;
        if (data0[1] !== 1'b1) $display("FAIL stretched_during_hold: got %b want 1", data0[1]);
        else n_pass++;
        ctrl_out[1] = 1'b0;
        cycles(1);
        n_total++;
        if (data0[1] !== 1'b1) $display("FAIL stretched_b: got %b want 1", data0[1]);
        else n_pass++;
        read_pulse(1);
        n_total++;
        if (data0[1] !== 1'b0) $display("FAIL stretched_select: got %b want 0", data0[1]);
        else n_pass++;
    endtask

    task automatic test_debounce();
        buttons0 = 8'h00;
        cycles(20);
        buttons0 = 8'h01;
        cycles(5);
        buttons0 = 8'h00;
        cycles(4);
        latch();
        n_total++;
        if (data_db[0] !== 1'b0) $display("FAIL debounce_glitch: got %b want 0", data_db[0]);
        else n_pass++;
        buttons0 = 8'h01;
        cycles(7);
        latch();
        n_total++;
        if (data_db[0] !== 1'b0) $display("FAIL debounce_early: got %b want 0", data_db[0]);
        else n_pass++;
        cycles(5);
        latch();
        n_total++;
        if (data_db[0] !== 1'b1) $display("FAIL debounce_held: got %b want 1", data_db[0]);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        buttons0 = 8'h0A;
        buttons1 = 8'h03;
        cycles(4);
        latch();
        for (int i = 0; i < 3; i++) read_pulse(0);
        n_total++;
        if (data0[0] !== 1'b1) $display("FAIL reset_mid_bit3: got %b want 1", data0[0]);
        else n_pass++;
        rst = 1'b1;
        cycles(1);
        rst = 1'b0;
        n_total++;
        if (data0 !== 2'b00) $display("FAIL reset_mid_clear: got %b want 00", data0);
        else n_pass++;
        cycles(3);
        latch();
        n_total++;
        if (data0 !== 2'b10) $display("FAIL reset_mid_relatch: got %b want 10", data0);
        else n_pass++;
        read_pulse(0);
        n_total++;
        if (data0[0] !== 1'b1) $display("FAIL reset_mid_b: got %b want 1", data0[0]);
        else n_pass++;
    endtask

    task automatic test_independence();
        buttons0 = 8'hFF;
        buttons1 = 8'h00;
        cycles(4);
        latch();
        for (int i = 0; i < 8; i++) begin
            n_total++;
            if (data0 !== 2'b01) $display("FAIL independence[%0d]: got %b want 01", i, data0);
            else n_pass++;
            read_pulse(0);
        end
        n_total++;
        if (data0 !== 2'b01) $display("FAIL independence_after8: got %b want 01", data0);
        else n_pass++;
    endtask

    task automatic test_both();
        buttons0 = 8'h01;
        buttons1 = 8'h02;
        cycles(4);
        latch();
        n_total++;
        if (data0 !== 2'b01) $display("FAIL both_latch: got %b want 01", data0);
        else n_pass++;
        ctrl_out = 2'b11;
        cycles(1);
        ctrl_out = 2'b00;
        cycles(1);
        n_total++;
        if (data0 !== 2'b10) $display("FAIL both_shift: got %b want 10", data0);
        else n_pass++;
    endtask

    initial begin
        rst         = 1'b1;
        ctrl_strobe = 3'b000;
        ctrl_out    = 2'b00;
        buttons0    = 8'h00;
        buttons1    = 8'h00;
        cycles(1);
        test_reset();
        test_latch_read();
        test_strobe_held();
        test_stretched();
        test_debounce();
        test_reset_mid();
        test_independence();
        test_both();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
